// File: rtl/i2c_bus_arb_pkg.sv
// Shared types for the two-requester I2C bus arbiter.
package i2c_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OWNED     = 2'd1,
        STOP_WAIT = 2'd2
    } arb_state_e;

    localparam int NumReq = 2;

    typedef logic [$clog2(NumReq)-1:0] req_idx_t;

    function automatic logic [NumReq-1:0] idx_to_onehot(req_idx_t idx);
        return NumReq'(1) << idx;
    endfunction

endpackage

// File: rtl/i2c_cond_detect.sv
// Registers the resolved bus lines once and flags START, STOP and any line change.
module i2c_cond_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bus_scl_i,
    input  logic bus_sda_i,
    output logic scl_q_o,
    output logic start_o,
    output logic stop_o,
    output logic activity_o
);

    logic scl_q_reg;
    logic sda_q_reg;
    logic scl_qq_reg;
    logic sda_qq_reg;

    // Lines reset to the released level so reset release never looks like a bus condition.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_q_reg  <= 1'b1;
            sda_q_reg  <= 1'b1;
            scl_qq_reg <= 1'b1;
            sda_qq_reg <= 1'b1;
        end else begin
            scl_q_reg  <= bus_scl_i;
            sda_q_reg  <= bus_sda_i;
            scl_qq_reg <= scl_q_reg;
            sda_qq_reg <= sda_q_reg;
        end
    end

    assign scl_q_o    = scl_q_reg;
    assign start_o    = scl_q_reg & sda_qq_reg & ~sda_q_reg;
    assign stop_o     = scl_q_reg & ~sda_qq_reg & sda_q_reg;
    assign activity_o = (scl_q_reg ^ scl_qq_reg) | (sda_q_reg ^ sda_qq_reg);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Grants a shared open-drain I2C bus to one of two hosts on their START attempt and
// forwards only the owner's drive; releases on STOP or owner inactivity.
module i2c_bus_arbiter
    import i2c_bus_arb_pkg::*;
#(
    parameter int TimeoutCycles = 25000,
    parameter int BusFreeCycles = 120
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_scl_o_i,
    input  logic [NumReq-1:0] req_scl_en_i,
    input  logic [NumReq-1:0] req_sda_o_i,
    input  logic [NumReq-1:0] req_sda_en_i,
    output logic [NumReq-1:0] req_scl_o,
    output logic [NumReq-1:0] req_sda_o,
    input  logic              bus_scl_i,
    input  logic              bus_sda_i,
    output logic              bus_scl_pull_o,
    output logic              bus_sda_pull_o,
    output logic [NumReq-1:0] grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int ToW   = $clog2(TimeoutCycles) + 1;
    localparam int FreeW = $clog2(BusFreeCycles) + 1;

    arb_state_e        state_reg;
    logic [NumReq-1:0] grant_reg;
    logic              timeout_reg;
    req_idx_t          rr_ptr_reg;
    logic [ToW-1:0]    to_cnt_reg;
    logic [FreeW-1:0]  free_cnt_reg;

    logic [NumReq-1:0] scl_pull;
    logic [NumReq-1:0] sda_pull;
    logic [NumReq-1:0] req_cond;
    logic              scl_q;
    logic              bus_start;
    logic              bus_stop;
    logic              line_change;
    logic              activity;

    i2c_cond_detect u_cond_detect (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bus_scl_i  (bus_scl_i),
        .bus_sda_i  (bus_sda_i),
        .scl_q_o    (scl_q),
        .start_o    (bus_start),
        .stop_o     (bus_stop),
        .activity_o (line_change)
    );

    // START/STOP are line changes already; folded in so any bus condition counts as activity.
    assign activity = line_change | bus_start | bus_stop;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
        assign scl_pull[gi]  = req_scl_en_i[gi] & ~req_scl_o_i[gi];
        assign sda_pull[gi]  = req_sda_en_i[gi] & ~req_sda_o_i[gi];
        assign req_cond[gi]  = sda_pull[gi] & ~scl_pull[gi] & scl_q;
        assign req_scl_o[gi] = bus_scl_i;
        assign req_sda_o[gi] = bus_sda_i;
    end

    // grant_reg is one-hot or zero, so the masked OR selects exactly the owner's drive.
    assign bus_scl_pull_o = |(scl_pull & grant_reg);
    assign bus_sda_pull_o = |(sda_pull & grant_reg);
    assign grant_o        = grant_reg;
    assign busy_o         = (state_reg != IDLE);
    assign timeout_o      = timeout_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            timeout_reg  <= 1'b0;
            rr_ptr_reg   <= '0;
            to_cnt_reg   <= '0;
            free_cnt_reg <= '0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    to_cnt_reg   <= '0;
                    free_cnt_reg <= '0;
                    if (&req_cond) begin
                        grant_reg  <= idx_to_onehot(rr_ptr_reg);
                        rr_ptr_reg <= ~rr_ptr_reg;
                        state_reg  <= OWNED;
                    end else if (|req_cond) begin
                        grant_reg <= req_cond;
                        state_reg <= OWNED;
                    end
                end
                OWNED: begin
                    if (bus_stop) begin
                        grant_reg <= '0;
                        state_reg <= STOP_WAIT;
                    end else if (activity) begin
                        to_cnt_reg <= '0;
                    end else if (to_cnt_reg >= ToW'(TimeoutCycles - 1)) begin
                        grant_reg   <= '0;
                        timeout_reg <= 1'b1;
                        state_reg   <= STOP_WAIT;
                    end else if (to_cnt_reg != '1) begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                STOP_WAIT: begin
                    if (free_cnt_reg >= FreeW'(BusFreeCycles - 1)) begin
                        free_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else if (free_cnt_reg != '1) begin
                        free_cnt_reg <= free_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for the I2C bus arbiter: drive-muxing table plus grant/release sequences.
module tb_i2c_bus_arbiter;

    logic       clk_i;
    logic       rst_ni;
    logic [1:0] req_scl_o_i;
    logic [1:0] req_scl_en_i;
    logic [1:0] req_sda_o_i;
    logic [1:0] req_sda_en_i;
    logic [1:0] req_scl_o;
    logic [1:0] req_sda_o;
    logic       bus_scl_i;
    logic       bus_sda_i;
    logic       bus_scl_pull_o;
    logic       bus_sda_pull_o;
    logic [1:0] grant_o;
    logic       busy_o;
    logic       timeout_o;
    logic       ext_sda_pull;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0] scl_o;
        logic [1:0] scl_en;
        logic [1:0] sda_o;
        logic [1:0] sda_en;
        logic       exp_scl_pull;
        logic       exp_sda_pull;
    } vec_t;

    vec_t vecs [8];

    i2c_bus_arbiter #(
        .TimeoutCycles (100),
        .BusFreeCycles (120)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_scl_o_i    (req_scl_o_i),
        .req_scl_en_i   (req_scl_en_i),
        .req_sda_o_i    (req_sda_o_i),
        .req_sda_en_i   (req_sda_en_i),
        .req_scl_o      (req_scl_o),
        .req_sda_o      (req_sda_o),
        .bus_scl_i      (bus_scl_i),
        .bus_sda_i      (bus_sda_i),
        .bus_scl_pull_o (bus_scl_pull_o),
        .bus_sda_pull_o (bus_sda_pull_o),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    // Wired-AND bus with pull-ups; ext_sda_pull stands in for a foreign host.
    assign bus_scl_i = ~bus_scl_pull_o;
    assign bus_sda_i = ~(bus_sda_pull_o | ext_sda_pull);

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("check %s ok (%0h)", name, act);
        end
    endtask

    task automatic set_req(input int k, input logic scl_pull, input logic sda_pull);
        req_scl_en_i[k] = scl_pull;
        req_scl_o_i[k]  = ~scl_pull;
        req_sda_en_i[k] = sda_pull;
        req_sda_o_i[k]  = ~sda_pull;
    endtask

    task automatic wait_grant(input logic [1:0] val, input int limit, output int n);
        n = 0;
        while (grant_o !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_busy(input logic val, input int limit, output int n);
        n = 0;
        while (busy_o !== val && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_timeout(input int limit, output int n);
        n = 0;
        while (timeout_o !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Release every requester line; a STOP on the bus drops the grant two edges later.
    task automatic do_stop(input string name);
        int n;
        set_req(0, 1'b0, 1'b0);
        set_req(1, 1'b0, 1'b0);
        wait_grant(2'b00, 10, n);
        check({name, "_stop_latency"}, n, 2);
        check({name, "_stopwait_busy"}, busy_o, 1'b1);
        check({name, "_no_timeout"}, timeout_o, 1'b0);
    endtask

    initial begin
        int n;
        // Owner is requester 0 throughout; requester 1 tries to interfere in v1..v6.
        vecs[0] = '{scl_o: 2'b11, scl_en: 2'b00, sda_o: 2'b10, sda_en: 2'b01, exp_scl_pull: 1'b0, exp_sda_pull: 1'b1};
        vecs[1] = '{scl_o: 2'b01, scl_en: 2'b10, sda_o: 2'b00, sda_en: 2'b11, exp_scl_pull: 1'b0, exp_sda_pull: 1'b1};
        vecs[2] = '{scl_o: 2'b00, scl_en: 2'b11, sda_o: 2'b00, sda_en: 2'b11, exp_scl_pull: 1'b1, exp_sda_pull: 1'b1};
        vecs[3] = '{scl_o: 2'b00, scl_en: 2'b11, sda_o: 2'b00, sda_en: 2'b10, exp_scl_pull: 1'b1, exp_sda_pull: 1'b0};
        vecs[4] = '{scl_o: 2'b00, scl_en: 2'b11, sda_o: 2'b01, sda_en: 2'b11, exp_scl_pull: 1'b1, exp_sda_pull: 1'b0};
        vecs[5] = '{scl_o: 2'b00, scl_en: 2'b11, sda_o: 2'b00, sda_en: 2'b11, exp_scl_pull: 1'b1, exp_sda_pull: 1'b1};
        vecs[6] = '{scl_o: 2'b01, scl_en: 2'b11, sda_o: 2'b00, sda_en: 2'b11, exp_scl_pull: 1'b0, exp_sda_pull: 1'b1};
        vecs[7] = '{scl_o: 2'b11, scl_en: 2'b01, sda_o: 2'b10, sda_en: 2'b01, exp_scl_pull: 1'b0, exp_sda_pull: 1'b1};

        rst_ni       = 1'b0;
        ext_sda_pull = 1'b0;
        set_req(0, 1'b0, 1'b0);
        set_req(1, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_grant", grant_o, 2'b00);
        check("reset_busy", busy_o, 1'b0);
        check("reset_timeout", timeout_o, 1'b0);
        check("reset_pulls", {bus_scl_pull_o, bus_sda_pull_o}, 2'b00);
        rst_ni = 1'b1;
        tick();
        tick();

        // Foreign START in IDLE: no grant, stays idle.
        ext_sda_pull = 1'b1;
        tick(); tick(); tick();
        check("ext_start_grant", grant_o, 2'b00);
        check("ext_start_busy", busy_o, 1'b0);
        ext_sda_pull = 1'b0;
        tick(); tick(); tick();

        // Simultaneous requests after reset: requester 0 wins.
        set_req(0, 1'b0, 1'b1);
        set_req(1, 1'b0, 1'b1);
        wait_grant(2'b01, 5, n);
        check("both_first_latency", n, 1);
        check("both_first_busy", busy_o, 1'b1);
        check("both_first_sda_pull", bus_sda_pull_o, 1'b1);
        check("both_first_scl_pull", bus_scl_pull_o, 1'b0);

        for (int i = 0; i < 8; i++) begin
            req_scl_o_i  = vecs[i].scl_o;
            req_scl_en_i = vecs[i].scl_en;
            req_sda_o_i  = vecs[i].sda_o;
            req_sda_en_i = vecs[i].sda_en;
            #1;
            check($sformatf("vec%0d_pulls", i), {bus_scl_pull_o, bus_sda_pull_o},
                  {vecs[i].exp_scl_pull, vecs[i].exp_sda_pull});
            check($sformatf("vec%0d_views", i), {req_scl_o, req_sda_o},
                  {{2{~vecs[i].exp_scl_pull}}, {2{~vecs[i].exp_sda_pull}}});
            check($sformatf("vec%0d_grant", i), grant_o, 2'b01);
            tick();
        end

        do_stop("first");
        wait_busy(1'b0, 200, n);
        check("first_free_cycles", n, 120);
        check("first_idle_grant", grant_o, 2'b00);

        // Second simultaneous request: pointer has moved to requester 1.
        set_req(0, 1'b0, 1'b1);
        set_req(1, 1'b0, 1'b1);
        wait_grant(2'b10, 5, n);
        check("both_second_latency", n, 1);
        tick();
        tick();
        do_stop("second");

        // Request during STOP_WAIT is ignored until IDLE, then granted one edge later.
        set_req(1, 1'b0, 1'b1);
        wait_busy(1'b0, 200, n);
        check("sw_free_cycles", n, 120);
        check("sw_no_grant", grant_o, 2'b00);
        wait_grant(2'b10, 5, n);
        check("sw_grant_latency", n, 1);
        tick();
        tick();
        check("r1_owner_sda_pull", bus_sda_pull_o, 1'b1);

        // Reset while requester 1 owns and pulls SDA.
        rst_ni = 1'b0;
        tick();
        check("midrst_pulls", {bus_scl_pull_o, bus_sda_pull_o}, 2'b00);
        check("midrst_grant", grant_o, 2'b00);
        check("midrst_busy", busy_o, 1'b0);
        set_req(1, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();

        // Requester 0 alone, then static bus: START reaches the activity detector two
        // edges after the grant, followed by 100 static cycles.
        set_req(0, 1'b0, 1'b1);
        wait_grant(2'b01, 5, n);
        check("solo_latency", n, 1);
        check("solo_sda_pull", bus_sda_pull_o, 1'b1);
        wait_timeout(300, n);
        check("timeout_edges", n, 102);
        check("timeout_grant", grant_o, 2'b00);
        check("timeout_busy", busy_o, 1'b1);
        tick();
        check("timeout_pulse_width", timeout_o, 1'b0);
        set_req(0, 1'b0, 1'b0);
        wait_busy(1'b0, 200, n);
        check("timeout_free_cycles", n, 119);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
